// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states,
// iteration count and the divide-by-zero LO value.
package mdu_pkg;

  localparam int MDU_ITERS = 32;
  localparam int MDU_CNT_W = 6;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  localparam logic [31:0] MDU_DBZ_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/mdu_sign_fix.sv
// Sign conditioning for the multiply/divide unit: magnitudes and sign bits of
// the raw operands on the way in, and sign restoration of the unsigned
// iterative result on the way out.
module mdu_sign_fix
  import mdu_pkg::*;
(
  input  logic        i_signed,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_abs_a,
  output logic [31:0] o_abs_b,
  output logic        o_sign_a,
  output logic        o_sign_b,
  input  logic [63:0] i_res,
  input  logic        i_is_mul,
  input  logic        i_neg_q,
  input  logic        i_neg_r,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  logic [63:0] w_neg64;
  logic [31:0] w_neg_hi;
  logic [31:0] w_neg_lo;

  // Operand magnitudes; unsigned ops pass the operands through untouched
  always_comb begin
    o_sign_a = i_signed & i_a[31];
    o_sign_b = i_signed & i_b[31];
    o_abs_a  = o_sign_a ? (32'd0 - i_a) : i_a;
    o_abs_b  = o_sign_b ? (32'd0 - i_b) : i_b;
  end

  // Product negates as one 64-bit value; quotient and remainder negate separately
  always_comb begin
    w_neg64  = 64'd0 - i_res;
    w_neg_hi = 32'd0 - i_res[63:32];
    w_neg_lo = 32'd0 - i_res[31:0];
    if (i_is_mul) begin
      o_hi = i_neg_q ? w_neg64[63:32] : i_res[63:32];
      o_lo = i_neg_q ? w_neg64[31:0]  : i_res[31:0];
    end else begin
      o_hi = i_neg_r ? w_neg_hi : i_res[63:32];
      o_lo = i_neg_q ? w_neg_lo : i_res[31:0];
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Optional macro MDU_FAST_MUL_EN: MULT/MULTU finish in a single cycle using a
// combinational 64-bit multiply; divide remains iterative.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int ITERS = MDU_ITERS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero
);

  if (ITERS != MDU_ITERS) begin : g_iters_chk
    $error("mul_div_unit: ITERS must equal the operand width (32)");
  end

  mdu_state_t           r_state;
  mdu_state_t           w_next;
  logic [MDU_CNT_W-1:0] r_cnt;
  logic [63:0]          r_acc;
  logic [31:0]          r_opb;
  logic                 r_is_mul, r_neg_q, r_neg_r, r_dbz_pend;
  logic                 r_done, r_dbz;
  logic [31:0]          r_hi, r_lo;

  logic        w_accept, w_op_mul, w_op_div, w_signed, w_iter_op;
  logic [31:0] w_abs_a, w_abs_b, w_fix_hi, w_fix_lo, w_div_diff;
  logic        w_sign_a, w_sign_b, w_div_ge;
  logic [32:0] w_mul_sum;
  logic [63:0] w_acc_step;
`ifdef MDU_FAST_MUL_EN
  logic [63:0] w_fast_prod;
`endif

  // Decode of the request presented in IDLE
  always_comb begin
    w_accept  = start && (r_state == IDLE);
    w_op_mul  = (op == MDU_MULT) || (op == MDU_MULTU);
    w_op_div  = (op == MDU_DIV)  || (op == MDU_DIVU);
    w_signed  = (op == MDU_MULT) || (op == MDU_DIV);
`ifdef MDU_FAST_MUL_EN
    w_iter_op = w_op_div;
    // Sign/zero-extended 64-bit multiply: the low 64 bits are right for both signednesses
    w_fast_prod = {{32{w_signed & in1[31]}}, in1} * {{32{w_signed & in2[31]}}, in2};
`else
    w_iter_op = w_op_mul || w_op_div;
`endif
  end

  mdu_sign_fix u_sign_fix (
    .i_signed (w_signed),
    .i_a      (in1),
    .i_b      (in2),
    .o_abs_a  (w_abs_a),
    .o_abs_b  (w_abs_b),
    .o_sign_a (w_sign_a),
    .o_sign_b (w_sign_b),
    .i_res    (r_acc),
    .i_is_mul (r_is_mul),
    .i_neg_q  (r_neg_q),
    .i_neg_r  (r_neg_r),
    .o_hi     (w_fix_hi),
    .o_lo     (w_fix_lo)
  );

  // One iteration: multiply shifts the 33-bit partial sum down into the
  // multiplier bits; divide shifts the remainder:dividend pair left and
  // subtracts the divisor when it fits
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opb} : 33'd0);
    w_div_ge   = r_acc[63:31] >= {1'b0, r_opb};
    w_div_diff = r_acc[62:31] - r_opb;
    if (r_is_mul)
      w_acc_step = {w_mul_sum, r_acc[31:1]};
    else if (w_div_ge)
      w_acc_step = {w_div_diff, r_acc[30:0], 1'b1};
    else
      w_acc_step = {r_acc[62:0], 1'b0};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept && w_iter_op) w_next = CALC;
      CALC:    if (r_cnt == MDU_CNT_W'(ITERS - 1)) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // FSM outputs and register-driven ports
  always_comb begin
    busy        = (r_state != IDLE);
    done        = r_done;
    hi          = r_hi;
    lo          = r_lo;
    div_by_zero = r_dbz;
  end

  // Iteration datapath: operand latch on accept, one step per CALC edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_opb      <= '0;
      r_is_mul   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dbz_pend <= 1'b0;
    end else if (r_state == IDLE) begin
      if (w_accept && w_iter_op) begin
        r_cnt      <= '0;
        r_is_mul   <= w_op_mul;
        r_neg_q    <= w_sign_a ^ w_sign_b;
        r_neg_r    <= w_sign_a;
        r_dbz_pend <= w_op_div && (in2 == 32'd0);
        r_acc      <= {32'd0, (w_op_mul ? w_abs_b : w_abs_a)};
        r_opb      <= w_op_mul ? w_abs_a : w_abs_b;
      end
    end else if (r_state == CALC) begin
      r_cnt <= r_cnt + MDU_CNT_W'(1);
      r_acc <= w_acc_step;
    end
  end

  // Architectural HI/LO, done pulse and divide-by-zero flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        case (op)
          MDU_MTHI: begin r_hi <= in1; r_done <= 1'b1; r_dbz <= 1'b0; end
          MDU_MTLO: begin r_lo <= in1; r_done <= 1'b1; r_dbz <= 1'b0; end
`ifdef MDU_FAST_MUL_EN
          MDU_MULT, MDU_MULTU: begin
            r_hi   <= w_fast_prod[63:32];
            r_lo   <= w_fast_prod[31:0];
            r_done <= 1'b1;
            r_dbz  <= 1'b0;
          end
          MDU_DIV, MDU_DIVU: r_dbz <= 1'b0;
`else
          MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: r_dbz <= 1'b0;
`endif
          default:  r_done <= 1'b1;
        endcase
      end else if (r_state == FIX) begin
        r_hi   <= w_fix_hi;
        r_lo   <= r_dbz_pend ? MDU_DBZ_LO : w_fix_lo;
        r_dbz  <= r_dbz_pend;
        r_done <= 1'b1;
      end
    end
  end

endmodule
